// File: rtl/pb_pkg.sv
// Shared types and defaults for the push-button pulser: FSM state encoding,
// default timing constants and a small max helper for counter sizing.
package pb_pkg;

  typedef logic [1:0] pb_state_t;

  localparam pb_state_t IDLE       = 2'd0;
  localparam pb_state_t DB_PRESS   = 2'd1;
  localparam pb_state_t HELD       = 2'd2;
  localparam pb_state_t DB_RELEASE = 2'd3;

  localparam int PB_DEBOUNCE_CYCLES_DEF = 50000;
  localparam int PB_REPEAT_DELAY_DEF    = 25000000;
  localparam int PB_REPEAT_PERIOD_DEF   = 5000000;

  function automatic int pb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level, async active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pb_pulser.sv
// Debounced push-button to one-cycle strobe, capturing SerIn with each strobe.
// Optional auto-repeat while held is enabled by defining PB_AUTO_REPEAT_EN.
module pb_pulser
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = PB_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = PB_REPEAT_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clkPB,
  input  logic SerIn,
  output logic clkEn,
  output logic SerBit,
  output logic pbLevel
);

`ifdef PB_AUTO_REPEAT_EN
  localparam int CW = $clog2(pb_max(DEBOUNCE_CYCLES, pb_max(REPEAT_DELAY, REPEAT_PERIOD)));
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`else
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
`endif
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("pb_pulser: timing parameter out of range");
  end

  logic pb_s, si_s;

  sync2 u_sync_pb (.clk(clock), .rst_n(reset), .d(clkPB), .q(pb_s));
  sync2 u_sync_si (.clk(clock), .rst_n(reset), .d(SerIn), .q(si_s));

  pb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_en_q, clk_en_d;
  logic          ser_bit_q, ser_bit_d;
  logic          pb_level_q, pb_level_d;
  logic          fire;
`ifdef PB_AUTO_REPEAT_EN
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_periodic_q, rpt_periodic_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ser_bit_d  = ser_bit_q;
    pb_level_d = pb_level_q;
    fire       = 1'b0;
`ifdef PB_AUTO_REPEAT_EN
    rpt_cnt_d      = rpt_cnt_q;
    rpt_periodic_d = rpt_periodic_q;
`endif

    case (state_q)
      IDLE: begin
        if (pb_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!pb_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d    = HELD;
          pb_level_d = 1'b1;
          fire       = 1'b1;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pb_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        // A high sample here is bounce on release: back to HELD, no strobe.
        if (pb_s) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d    = IDLE;
          pb_level_d = 1'b0;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef PB_AUTO_REPEAT_EN
    // Every entry into HELD restarts the long initial delay.
    if (state_d == HELD && state_q != HELD) begin
      rpt_cnt_d      = '0;
      rpt_periodic_d = 1'b0;
    end else if (state_q == HELD && pb_s) begin
      if (rpt_cnt_q == (rpt_periodic_q ? RP_LAST : RD_LAST)) begin
        fire           = 1'b1;
        rpt_cnt_d      = '0;
        rpt_periodic_d = 1'b1;
      end else begin
        rpt_cnt_d = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
      end
    end
`endif

    clk_en_d = fire & ~clk_en_q;
    if (clk_en_d) begin
      ser_bit_d = si_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_en_q   <= 1'b0;
      ser_bit_q  <= 1'b0;
      pb_level_q <= 1'b0;
`ifdef PB_AUTO_REPEAT_EN
      rpt_cnt_q      <= '0;
      rpt_periodic_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      ser_bit_q  <= ser_bit_d;
      pb_level_q <= pb_level_d;
`ifdef PB_AUTO_REPEAT_EN
      rpt_cnt_q      <= rpt_cnt_d;
      rpt_periodic_q <= rpt_periodic_d;
`endif
    end
  end

  assign clkEn   = clk_en_q;
  assign SerBit  = ser_bit_q;
  assign pbLevel = pb_level_q;

endmodule

// File: tb/tb_pb_pulser.sv
// Self-checking bench for pb_pulser (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Reference model: a level is accepted once the synchronized input has disagreed with it for DB+1 samples in a row.
module tb_pb_pulser;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clock, reset, clkPB, SerIn;
  logic clkEn, SerBit, pbLevel;

  int vectors;
  int miscompares;

  pb_pulser #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clock(clock), .reset(reset), .clkPB(clkPB), .SerIn(SerIn),
    .clkEn(clkEn), .SerBit(SerBit), .pbLevel(pbLevel)
  );

  always #5 clock = ~clock;

  // Reference model state
  bit pd1, pd2, sd1, sd2;
  bit lvl, exp_en, exp_ser;
  int run;
`ifdef PB_AUTO_REPEAT_EN
  int elapsed;
  bit first;
`endif

  task automatic model_reset();
    pd1 = 0; pd2 = 0; sd1 = 0; sd2 = 0;
    lvl = 0; exp_en = 0; exp_ser = 0; run = 0;
`ifdef PB_AUTO_REPEAT_EN
    elapsed = 0; first = 1;
`endif
  endtask

  task automatic model_edge(input logic pb, input logic si);
    bit syn_pb, syn_si;
`ifdef PB_AUTO_REPEAT_EN
    bit was_held, bounce_back;
    was_held    = lvl && (run == 0);
    bounce_back = lvl && (run > 0) && pd2;
`endif
    syn_pb = pd2; syn_si = sd2;
    pd2 = pd1; pd1 = pb; sd2 = sd1; sd1 = si;
    exp_en = 0;
    if (syn_pb != lvl) run++;
    else run = 0;
    if (run == DB + 1) begin
      lvl = !lvl;
      run = 0;
      if (lvl) begin
        exp_en = 1; exp_ser = syn_si;
`ifdef PB_AUTO_REPEAT_EN
        elapsed = 0; first = 1;
`endif
      end
    end
`ifdef PB_AUTO_REPEAT_EN
    else if (bounce_back) begin
      elapsed = 0; first = 1;
    end else if (was_held && syn_pb) begin
      elapsed++;
      if (elapsed == (first ? RD : RP)) begin
        exp_en = 1; exp_ser = syn_si; elapsed = 0; first = 0;
      end
    end
`endif
  endtask

  task automatic step(input logic pb, input logic si);
    clkPB = pb; SerIn = si;
    @(posedge clock);
    model_edge(pb, si);
    #1;
    if (clkEn) $display("pulse t=%0t SerBit=%b pbLevel=%b", $time, SerBit, pbLevel);
  endtask

  task automatic test_reset();
    reset = 0; clkPB = 0; SerIn = 0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({clkEn, SerBit, pbLevel} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state got=%b%b%b exp=000", clkEn, SerBit, pbLevel);
    end
    reset = 1;
    model_reset();
  endtask

  task automatic test_clean_press();
    int pulses, at;
    pulses = 0; at = -1;
    for (int i = 0; i < 8; i++) step(0, 1);
    for (int i = 0; i < 30; i++) begin
      step(1, 1);
      vectors++;
      if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
        miscompares++;
        $display("FAIL clean_press cyc=%0d got=%b%b%b exp=%b%b%b", i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
      end
      if (clkEn) begin pulses++; if (at < 0) at = i; end
    end
    vectors++;
    if (pulses !== 1 || at !== 6 || SerBit !== 1'b1 || pbLevel !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_press_summary pulses=%0d at=%0d SerBit=%b pbLevel=%b exp 1,6,1,1", pulses, at, SerBit, pbLevel);
    end
    for (int i = 0; i < 10; i++) step(0, 0);
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int pulses, at;
    pat = 4'b0101;  // applied LSB first: 1,0,1,0
    pulses = 0; at = -1;
    for (int i = 0; i < 24; i++) begin
      step((i < 4) ? pat[i] : 1'b1, 1'b0);
      vectors++;
      if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
        miscompares++;
        $display("FAIL bounce cyc=%0d got=%b%b%b exp=%b%b%b", i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
      end
      if (clkEn) begin pulses++; if (at < 0) at = i; end
    end
    vectors++;
    if (pulses !== 1 || at !== 10) begin
      miscompares++;
      $display("FAIL bounce_summary pulses=%0d at=%0d exp 1,10", pulses, at);
    end
    for (int i = 0; i < 10; i++) step(0, 0);
  endtask

  task automatic test_serial_sequence();
    logic [8:0] bits;
    logic [8:0] got;
    int pulses;
    bits = 9'b010110101;  // applied LSB first: 1,0,1,0,1,1,0,1,0
    got = '0; pulses = 0;
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < 20; i++) begin
        step(i < 10, bits[p]);
        vectors++;
        if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
          miscompares++;
          $display("FAIL serial p=%0d cyc=%0d got=%b%b%b exp=%b%b%b", p, i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
        end
        if (clkEn) begin
          if (pulses < 9) got[pulses] = SerBit;
          pulses++;
        end
      end
    end
    vectors++;
    if (pulses !== 9 || got !== bits) begin
      miscompares++;
      $display("FAIL serial_summary pulses=%0d bits=%b exp 9,%b", pulses, got, bits);
    end
  endtask

  task automatic test_release_glitch();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 29; i++) begin
      step(!(i == 12 || i == 13), 1'b1);
      vectors++;
      if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
        miscompares++;
        $display("FAIL glitch cyc=%0d got=%b%b%b exp=%b%b%b", i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
      end
      if (clkEn) pulses++;
      if (i >= 12 && (clkEn !== 1'b0 || pbLevel !== 1'b1)) begin
        miscompares++;
        $display("FAIL glitch_held cyc=%0d clkEn=%b pbLevel=%b exp 0,1", i, clkEn, pbLevel);
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL glitch_pulses got=%0d exp=1", pulses);
    end
    for (int i = 0; i < 10; i++) step(0, 1);
  endtask

  task automatic test_reset_mid_press();
    int pulses, at;
    pulses = 0; at = -1;
    for (int i = 0; i < 5; i++) step(1, 0);  // debounce counter now at 2
    reset = 0;
    #2;
    vectors++;
    if ({clkEn, SerBit, pbLevel} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_async got=%b%b%b exp=000", clkEn, SerBit, pbLevel);
    end
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({clkEn, SerBit, pbLevel} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_hold got=%b%b%b exp=000", clkEn, SerBit, pbLevel);
    end
    reset = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 1);
      vectors++;
      if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got=%b%b%b exp=%b%b%b", i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
      end
      if (clkEn) begin pulses++; if (at < 0) at = i; end
    end
    vectors++;
    if (pulses !== 1 || at !== 6) begin
      miscompares++;
      $display("FAIL reset_mid_summary pulses=%0d at=%0d exp 1,6", pulses, at);
    end
    for (int i = 0; i < 10; i++) step(0, 0);
  endtask

  task automatic test_auto_repeat();
    int times[$];
    int exp_times[$];
`ifdef PB_AUTO_REPEAT_EN
    exp_times = '{6, 26, 34, 42, 50, 58};
`else
    exp_times = '{6};
`endif
    for (int i = 0; i < 60; i++) begin
      step(1, i[0]);
      vectors++;
      if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
        miscompares++;
        $display("FAIL repeat cyc=%0d got=%b%b%b exp=%b%b%b", i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
      end
      if (clkEn) times.push_back(i);
    end
    vectors++;
    if (times != exp_times) begin
      miscompares++;
      $display("FAIL repeat_times got=%p exp=%p", times, exp_times);
    end
    for (int i = 0; i < 10; i++) step(0, 0);
  endtask

  task automatic test_random();
    logic lv, pb;
    int len;
    lv = 0;
    for (int s = 0; s < 40; s++) begin
      lv = ~lv;
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        pb = ($urandom_range(0, 3) == 0) ? ~lv : lv;
        step(pb, 1'($urandom));
        vectors++;
        if ({clkEn, SerBit, pbLevel} !== {exp_en, exp_ser, lvl}) begin
          miscompares++;
          $display("FAIL random seg=%0d cyc=%0d got=%b%b%b exp=%b%b%b", s, i, clkEn, SerBit, pbLevel, exp_en, exp_ser, lvl);
        end
      end
    end
  endtask

  initial begin
    clock = 0;
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_serial_sequence();
    test_release_glitch();
    test_reset_mid_press();
    test_auto_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
